adc_spi_responder: RTL and testbench



---
 rtl/adc_spi_responder_pkg.sv | 6 +
 rtl/adc_spi_responder_if.sv | 10 +
 rtl/adc_spi_responder_sync_edge.sv | 29 ++
 rtl/adc_spi_responder.sv | 140 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_responder_pkg.sv
// adc_spi_pkg: shared types and constants for the MCP3008-style SPI ADC responder.
package adc_spi_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_START, CONFIG, SAMPLE, NULL, DATA, TAIL, DONE} state_t;
    localparam int CFG_BITS = 4;
    localparam int CH_W = 3;
endpackage

// File: rtl/adc_spi_responder_if.sv
// adc_spi_if: SPI pins between an ADC initiator (master) and the responder (slave).
interface adc_spi_if;
    logic ad_clk;
    logic cs;
    logic din;
    logic dout;
    logic dout_oe;
    modport master (output ad_clk, cs, din, input dout, dout_oe);
    modport slave (input ad_clk, cs, din, output dout, dout_oe);
endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// sync_edge: multi-stage synchronizer for an asynchronous input with one-clk rise/fall strobes.
module sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{INIT}};
            r_prev <= INIT;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= w_q;
        end
    end

    assign w_q    = r_sync[STAGES-1];
    assign o_rise = w_q & ~r_prev;
    assign o_fall = ~w_q & r_prev;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: MCP3008-style 8-channel SPI ADC responder returning the
// selected channel of sample_data, MSB first, with an optional LSB-first tail.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_TAIL    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    adc_spi_if.slave                 spi,
    input  logic [N_CH*DATA_W-1:0]   sample_data,
    output logic                     req_valid,
    output logic [CH_W-1:0]          req_ch,
    output logic                     req_sgl,
    output logic                     frame_err
);
    localparam int CNT_W = $clog2(DATA_W > CFG_BITS ? DATA_W : CFG_BITS);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CFG_BITS - 1);

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [CFG_BITS-2:0]      r_cfg;
    logic [DATA_W-1:0]        r_shift;
    logic [SYNC_STAGES-1:0]   r_din_sync;
    logic [SYNC_STAGES:0]     r_boot;
    logic                     r_dout, r_oe, r_req_valid, r_req_sgl, r_frame_err;
    logic [CH_W-1:0]          r_req_ch;
    logic                     w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_din;
    logic [CFG_BITS-1:0]      w_cfg;
    logic [CNT_W-1:0]         w_idx;
    logic [DATA_W-1:0]        w_ch_val [2**CH_W];

    sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(spi.ad_clk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .i_d(spi.cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    for (genvar i = 0; i < 2**CH_W; i++) begin : g_ch
        if (i < N_CH) begin : g_v
            assign w_ch_val[i] = sample_data[i*DATA_W +: DATA_W];
        end else begin : g_z
            assign w_ch_val[i] = '0;
        end
    end

    assign w_din = r_din_sync[SYNC_STAGES-1];
    assign w_cfg = {r_cfg, w_din};
    assign w_idx = LAST - r_cnt;

    // A cs fall is only trusted once the synchronizer has flushed its reset
    // value, so a cs held low across reset cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cfg       <= '0;
            r_shift     <= '0;
            r_din_sync  <= '0;
            r_boot      <= '0;
            r_dout      <= 1'b0;
            r_oe        <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_ch    <= '0;
            r_req_sgl   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], spi.din};
            r_boot      <= {r_boot[SYNC_STAGES-1:0], 1'b1};
            r_req_valid <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_rise && r_state != IDLE) begin
                r_state     <= IDLE;
                r_oe        <= 1'b0;
                r_dout      <= 1'b0;
                r_frame_err <= r_state inside {CONFIG, SAMPLE, NULL, DATA};
            end else begin
                case (r_state)
                    IDLE: begin
                        r_oe   <= 1'b0;
                        r_dout <= 1'b0;
                        if (w_cs_fall && r_boot[SYNC_STAGES]) r_state <= WAIT_START;
                    end
                    WAIT_START: if (w_sclk_rise && w_din) begin
                        r_state <= CONFIG;
                        r_cnt   <= '0;
                    end
                    CONFIG: if (w_sclk_rise) begin
                        r_cfg <= w_cfg[CFG_BITS-2:0];
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CFG_LAST) begin
                            r_req_ch    <= w_cfg[CH_W-1:0];
                            r_req_sgl   <= w_cfg[CFG_BITS-1];
                            r_req_valid <= 1'b1;
                            r_shift     <= w_ch_val[w_cfg[CH_W-1:0]];
                            r_state     <= SAMPLE;
                        end
                    end
                    SAMPLE: if (w_sclk_fall) begin
                        r_oe    <= 1'b1;
                        r_dout  <= 1'b0;
                        r_state <= NULL;
                    end
                    NULL: if (w_sclk_fall) begin
                        r_dout  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= DATA;
                    end
                    DATA: if (w_sclk_fall) begin
                        r_dout <= r_shift[w_idx];
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= LSB_TAIL ? TAIL : DONE;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    TAIL: if (w_sclk_fall) begin
                        r_dout <= r_shift[r_cnt];
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST) r_state <= DONE;
                    end
                    DONE: if (w_sclk_fall) r_dout <= 1'b0;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign spi.dout    = r_dout;
    assign spi.dout_oe = r_oe;
    assign req_valid   = r_req_valid;
    assign req_ch      = r_req_ch;
    assign req_sgl     = r_req_sgl;
    assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed frames against adc_spi_responder with hand-computed DOUT streams.
module tb_adc_spi_responder;
    localparam int DATA_W = 10;
    localparam int N_CH   = 8;
    localparam int HALF   = 80;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH*DATA_W-1:0] sample_data;
    logic                   req_valid, req_sgl, frame_err;
    logic [2:0]             req_ch;
    int errors = 0;
    int checks = 0;
    int n_req  = 0;
    int n_ferr = 0;

    adc_spi_if spi();

    adc_spi_responder dut (
        .clk(clk), .rst_n(rst_n), .spi(spi.slave), .sample_data(sample_data),
        .req_valid(req_valid), .req_ch(req_ch), .req_sgl(req_sgl), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req_valid === 1'b1) n_req <= n_req + 1;
        if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
    end

    // DOUT is read just before each rising ad_clk, i.e. the value driven on the previous fall.
    task automatic xfer(input logic d, output logic q);
        spi.din = d;
        #HALF;
        q = spi.dout;
        spi.ad_clk = 1'b1;
        #HALF;
        spi.ad_clk = 1'b0;
    endtask

    task automatic frame_start(input logic sgl, input logic [2:0] ch);
        logic q;
        spi.cs = 1'b0;
        #HALF;
        for (int i = 0; i < 7; i++) xfer(1'b0, q);
        xfer(1'b1, q);
        xfer(sgl, q);
        xfer(ch[2], q);
        xfer(ch[1], q);
        xfer(ch[0], q);
    endtask

    task automatic read_bits(input int n, output logic [31:0] rx);
        logic q;
        rx = '0;
        for (int i = 0; i < n; i++) begin
            xfer(1'b0, q);
            rx = {rx[30:0], q};
        end
    endtask

    task automatic frame_end;
        #HALF;
        spi.cs = 1'b1;
        #(2*HALF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        spi.cs = 1'b1;
        spi.ad_clk = 1'b0;
        spi.din = 1'b0;
        sample_data = '0;
        #20;
        checks++; if (spi.dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", spi.dout); end
        checks++; if (spi.dout_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", spi.dout_oe); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (req_ch !== 3'd0) begin errors++; $display("FAIL reset_req_ch: got %0d expected 0", req_ch); end
        checks++; if (req_sgl !== 1'b0) begin errors++; $display("FAIL reset_req_sgl: got %b expected 0", req_sgl); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst_n = 1'b1;
        #100;
    endtask

    task automatic test_basic;
        logic [31:0] rx;
        int r0, e0;
        sample_data[5*DATA_W +: DATA_W] = 10'h2A5;
        r0 = n_req; e0 = n_ferr;
        frame_start(1'b1, 3'd5);
        read_bits(12, rx);
        checks++; if (rx[11:0] !== 12'h2A5) begin errors++; $display("FAIL basic_data: got %h expected 2a5", rx[11:0]); end
        checks++; if (spi.dout_oe !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b expected 1", spi.dout_oe); end
        checks++; if (n_req - r0 !== 1) begin errors++; $display("FAIL basic_req_count: got %0d expected 1", n_req - r0); end
        checks++; if (req_ch !== 3'd5) begin errors++; $display("FAIL basic_req_ch: got %0d expected 5", req_ch); end
        checks++; if (req_sgl !== 1'b1) begin errors++; $display("FAIL basic_req_sgl: got %b expected 1", req_sgl); end
        frame_end;
        checks++; if (spi.dout_oe !== 1'b0) begin errors++; $display("FAIL basic_end_oe: got %b expected 0", spi.dout_oe); end
        checks++; if (n_ferr - e0 !== 0) begin errors++; $display("FAIL basic_frame_err: got %0d expected 0", n_ferr - e0); end
    endtask

    task automatic test_tail;
        logic [31:0] rx;
        int e0;
        sample_data[0 +: DATA_W] = 10'h301;
        e0 = n_ferr;
        frame_start(1'b1, 3'd0);
        read_bits(23, rx);
        checks++; if (rx[22:0] !== {2'b00, 10'h301, 9'b000000011, 2'b00})
            begin errors++; $display("FAIL tail_stream: got %b expected %b", rx[22:0], {2'b00, 10'h301, 9'b000000011, 2'b00}); end
        frame_end;
        checks++; if (n_ferr - e0 !== 0) begin errors++; $display("FAIL tail_frame_err: got %0d expected 0", n_ferr - e0); end
    endtask

    task automatic test_abort;
        logic [31:0] rx;
        int e0;
        sample_data[3*DATA_W +: DATA_W] = 10'h155;
        e0 = n_ferr;
        frame_start(1'b1, 3'd3);
        read_bits(5, rx);
        checks++; if (rx[4:0] !== 5'b00010) begin errors++; $display("FAIL abort_partial: got %b expected 00010", rx[4:0]); end
        #HALF;
        spi.cs = 1'b1;
        #30;
        checks++; if (spi.dout_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b expected 0", spi.dout_oe); end
        #(2*HALF);
        checks++; if (n_ferr - e0 !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d expected 1", n_ferr - e0); end
        frame_start(1'b1, 3'd3);
        read_bits(12, rx);
        checks++; if (rx[11:0] !== 12'h155) begin errors++; $display("FAIL abort_next_data: got %h expected 155", rx[11:0]); end
        frame_end;
        checks++; if (n_ferr - e0 !== 1) begin errors++; $display("FAIL abort_next_err: got %0d expected 1", n_ferr - e0); end
    endtask

    task automatic test_snapshot;
        logic [31:0] rx1, rx2;
        sample_data[2*DATA_W +: DATA_W] = 10'h0FF;
        frame_start(1'b1, 3'd2);
        read_bits(4, rx1);
        sample_data[2*DATA_W +: DATA_W] = 10'h100;
        read_bits(8, rx2);
        checks++; if ({rx1[3:0], rx2[7:0]} !== 12'h0FF)
            begin errors++; $display("FAIL snapshot_data: got %h expected 0ff", {rx1[3:0], rx2[7:0]}); end
        frame_end;
    endtask

    task automatic test_mid_reset;
        logic [31:0] rx;
        int r0;
        sample_data[5*DATA_W +: DATA_W] = 10'h2A5;
        frame_start(1'b1, 3'd5);
        read_bits(6, rx);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (spi.dout !== 1'b0) begin errors++; $display("FAIL midrst_dout: got %b expected 0", spi.dout); end
        checks++; if (spi.dout_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe: got %b expected 0", spi.dout_oe); end
        #7;
        rst_n = 1'b1;
        r0 = n_req;
        frame_start(1'b1, 3'd5);
        read_bits(12, rx);
        checks++; if (n_req - r0 !== 0) begin errors++; $display("FAIL midrst_no_req: got %0d expected 0", n_req - r0); end
        checks++; if (spi.dout_oe !== 1'b0) begin errors++; $display("FAIL midrst_no_oe: got %b expected 0", spi.dout_oe); end
        frame_end;
        frame_start(1'b1, 3'd5);
        read_bits(12, rx);
        checks++; if (rx[11:0] !== 12'h2A5) begin errors++; $display("FAIL midrst_next_data: got %h expected 2a5", rx[11:0]); end
        frame_end;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rx;
        int e0;
        sample_data[7*DATA_W +: DATA_W] = 10'h3FF;
        sample_data[1*DATA_W +: DATA_W] = 10'h001;
        e0 = n_ferr;
        frame_start(1'b0, 3'd7);
        read_bits(12, rx);
        checks++; if (rx[11:0] !== 12'h3FF) begin errors++; $display("FAIL b2b_data7: got %h expected 3ff", rx[11:0]); end
        checks++; if (req_sgl !== 1'b0) begin errors++; $display("FAIL b2b_sgl: got %b expected 0", req_sgl); end
        checks++; if (req_ch !== 3'd7) begin errors++; $display("FAIL b2b_ch7: got %0d expected 7", req_ch); end
        #HALF;
        spi.cs = 1'b1;
        #(2*HALF);
        frame_start(1'b0, 3'd1);
        read_bits(12, rx);
        checks++; if (rx[11:0] !== 12'h001) begin errors++; $display("FAIL b2b_data1: got %h expected 001", rx[11:0]); end
        checks++; if (req_ch !== 3'd1) begin errors++; $display("FAIL b2b_ch1: got %0d expected 1", req_ch); end
        frame_end;
        checks++; if (n_ferr - e0 !== 0) begin errors++; $display("FAIL b2b_frame_err: got %0d expected 0", n_ferr - e0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_tail;
        test_abort;
        test_snapshot;
        test_mid_reset;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
